mips_debug_ctrl: RTL and testbench

Parametrised debug/control engine for the MIPS pipeline, the next generation of the debug unit. Sits between a byte-stream UART (RX/TX with valid/ready) and the pipeline: loads programs into instruction memory, runs continuously or single-steps, and dumps PC, a cycle counter, the register file and a data-memory window after every run or step. It adds several capabilities the current debug unit lacks:
- configurable register and memory dump sizes;
- a run timeout;
- a sticky halt flag;
- a dumped cycle counter.

---
 rtl/mips_debug_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_mips_debug_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_debug_ctrl.sv
// Debug/control engine between a byte UART and the MIPS pipeline: program load,
// run/step control, and a PC/cycle-counter/register/memory dump after each run.
module mips_debug_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int NREGS          = 32,
    parameter int DUMP_MEM_WORDS = 32,
    parameter int RUN_TIMEOUT    = 0
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [DATA_WIDTH-1:0] o_instr_addr,
    output logic                  o_instr_we,
    output logic                  o_loading,
    output logic                  o_start,
    output logic                  o_step,
    input  logic                  i_finish,
    input  logic [DATA_WIDTH-1:0] i_pc,
    output logic [4:0]            o_reg_addr,
    input  logic [DATA_WIDTH-1:0] i_reg,
    output logic [DATA_WIDTH-1:0] o_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int NWORDS = 2 + NREGS + DUMP_MEM_WORDS;
    localparam int IDXW   = $clog2(NWORDS + 1);

    typedef enum logic [3:0] {
        IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR, RUN, STEP, SETTLE,
        DUMP_ADDR, DUMP_SAMPLE, DUMP_SEND
    } state_t;

    state_t                state_q;
    logic [7:0]            cnt_q, word_q;
    logic [BW-1:0]         byte_q;
    logic [IDXW-1:0]       widx_q;
    logic [DATA_WIDTH-1:0] shift_q, instr_q, instr_addr_q, cyc_q, run_q, mem_addr_q;
    logic [4:0]            reg_addr_q;
    logic                  we_q, loading_q, start_q, step_q, tx_valid_q, halted_q;

    logic [IDXW-1:0]       widx_d;
    logic [4:0]            reg_addr_d;
    logic [DATA_WIDTH-1:0] mem_addr_d, run_d, dump_word;
    logic                  timeout;

    assign widx_d     = widx_q + IDXW'(1);
    assign reg_addr_d = 5'(widx_d - IDXW'(2));
    assign mem_addr_d = DATA_WIDTH'(widx_d - IDXW'(2 + NREGS)) << 2;
    assign run_d      = run_q + DATA_WIDTH'(1);
    assign timeout    = (RUN_TIMEOUT != 0) && (run_d == DATA_WIDTH'(RUN_TIMEOUT));

    // Word layout of a dump: PC, cycle counter, registers, then memory.
    always_comb begin
        dump_word = i_mem;
        if (widx_q == '0)
            dump_word = i_pc;
        else if (widx_q == IDXW'(1))
            dump_word = cyc_q;
        else if (widx_q < IDXW'(2 + NREGS))
            dump_word = i_reg;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            word_q       <= '0;
            byte_q       <= '0;
            widx_q       <= '0;
            shift_q      <= '0;
            instr_q      <= '0;
            instr_addr_q <= '0;
            cyc_q        <= '0;
            run_q        <= '0;
            mem_addr_q   <= '0;
            reg_addr_q   <= '0;
            we_q         <= 1'b0;
            loading_q    <= 1'b0;
            start_q      <= 1'b0;
            step_q       <= 1'b0;
            tx_valid_q   <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            step_q <= 1'b0;
            case (state_q)
                IDLE: if (i_rx_valid) begin
                    case (i_rx_data)
                        8'h4C: begin
                            state_q   <= LOAD_CNT;
                            loading_q <= 1'b1;
                        end
                        8'h43: begin
                            widx_q <= '0;
                            if (halted_q) begin
                                state_q <= DUMP_ADDR;
                            end else begin
                                state_q <= RUN;
                                start_q <= 1'b1;
                                run_q   <= '0;
                            end
                        end
                        8'h53: begin
                            widx_q <= '0;
                            if (halted_q) begin
                                state_q <= DUMP_ADDR;
                            end else begin
                                state_q <= STEP;
                                step_q  <= 1'b1;
                            end
                        end
                        8'h44: begin
                            widx_q  <= '0;
                            state_q <= DUMP_ADDR;
                        end
                        default: ;
                    endcase
                end
                LOAD_CNT: if (i_rx_valid) begin
                    if (i_rx_data == 8'd0) begin
                        state_q   <= IDLE;
                        loading_q <= 1'b0;
                    end else begin
                        cnt_q   <= i_rx_data;
                        word_q  <= '0;
                        byte_q  <= '0;
                        state_q <= LOAD_BYTE;
                    end
                end
                LOAD_BYTE: if (i_rx_valid) begin
                    // Bytes arrive LSB first: shift in from the top.
                    instr_q <= (instr_q >> 8) | (DATA_WIDTH'(i_rx_data) << (DATA_WIDTH - 8));
                    if (byte_q == BW'(NBYTES - 1)) begin
                        byte_q       <= '0;
                        we_q         <= 1'b1;
                        instr_addr_q <= DATA_WIDTH'(word_q) << 2;
                        state_q      <= LOAD_WR;
                    end else begin
                        byte_q <= byte_q + BW'(1);
                    end
                end
                LOAD_WR: begin
                    word_q <= word_q + 8'd1;
                    if (word_q == cnt_q - 8'd1) begin
                        state_q   <= IDLE;
                        loading_q <= 1'b0;
                    end else begin
                        state_q <= LOAD_BYTE;
                    end
                end
                RUN: begin
                    cyc_q <= cyc_q + DATA_WIDTH'(1);
                    run_q <= run_d;
                    if (i_finish || timeout) begin
                        start_q <= 1'b0;
                        state_q <= DUMP_ADDR;
                        if (i_finish)
                            halted_q <= 1'b1;
                    end
                end
                STEP: begin
                    cyc_q   <= cyc_q + DATA_WIDTH'(1);
                    state_q <= SETTLE;
                    if (i_finish)
                        halted_q <= 1'b1;
                end
                SETTLE: begin
                    state_q <= DUMP_ADDR;
                    if (i_finish)
                        halted_q <= 1'b1;
                end
                DUMP_ADDR: state_q <= DUMP_SAMPLE;
                DUMP_SAMPLE: begin
                    shift_q    <= dump_word;
                    byte_q     <= '0;
                    tx_valid_q <= 1'b1;
                    state_q    <= DUMP_SEND;
                end
                DUMP_SEND: if (i_tx_ready) begin
                    if (byte_q == BW'(NBYTES - 1)) begin
                        tx_valid_q <= 1'b0;
                        if (widx_q == IDXW'(NWORDS - 1)) begin
                            state_q <= IDLE;
                        end else begin
                            widx_q  <= widx_d;
                            state_q <= DUMP_ADDR;
                            // Read address is set up on entry so data is ready in DUMP_SAMPLE.
                            if (widx_d >= IDXW'(2 + NREGS))
                                mem_addr_q <= mem_addr_d;
                            else if (widx_d >= IDXW'(2))
                                reg_addr_q <= reg_addr_d;
                        end
                    end else begin
                        shift_q <= shift_q >> 8;
                        byte_q  <= byte_q + BW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_tx_data    = shift_q[7:0];
    assign o_tx_valid   = tx_valid_q;
    assign o_instr      = instr_q;
    assign o_instr_addr = instr_addr_q;
    assign o_instr_we   = we_q;
    assign o_loading    = loading_q;
    assign o_start      = start_q;
    assign o_step       = step_q;
    assign o_reg_addr   = reg_addr_q;
    assign o_mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Directed bench for mips_debug_ctrl: load, step, run, halted, backpressure,
// reset mid-transfer, and a second instance exercising the run timeout.
module tb_mips_debug_ctrl;
    logic        clk, rst;
    logic [7:0]  rx_data;
    logic        rx_valid, rx2_valid, tx_ready, finish;
    logic [31:0] pc;
    logic [31:0] reg_rd, mem_rd, reg2_rd, mem2_rd;

    logic [7:0]  o_tx_data, tx2_data;
    logic        o_tx_valid, tx2_valid, o_instr_we, instr2_we, o_loading, loading2;
    logic        o_start, start2, o_step, step2;
    logic [31:0] o_instr, instr2, o_instr_addr, instr2_addr, o_mem_addr, mem2_addr;
    logic [4:0]  o_reg_addr, reg2_addr;

    mips_debug_ctrl dut (
        .i_clock(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(tx_ready),
        .o_instr(o_instr), .o_instr_addr(o_instr_addr), .o_instr_we(o_instr_we),
        .o_loading(o_loading), .o_start(o_start), .o_step(o_step), .i_finish(finish),
        .i_pc(pc), .o_reg_addr(o_reg_addr), .i_reg(reg_rd), .o_mem_addr(o_mem_addr),
        .i_mem(mem_rd)
    );

    mips_debug_ctrl #(.NREGS(4), .DUMP_MEM_WORDS(2), .RUN_TIMEOUT(5)) dut2 (
        .i_clock(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_valid(rx2_valid),
        .o_tx_data(tx2_data), .o_tx_valid(tx2_valid), .i_tx_ready(tx_ready),
        .o_instr(instr2), .o_instr_addr(instr2_addr), .o_instr_we(instr2_we),
        .o_loading(loading2), .o_start(start2), .o_step(step2), .i_finish(1'b0),
        .i_pc(pc), .o_reg_addr(reg2_addr), .i_reg(reg2_rd), .o_mem_addr(mem2_addr),
        .i_mem(mem2_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rf(input logic [4:0] a);
        return 32'hC0DE_0000 + 32'(a) * 32'h0101;
    endfunction
    function automatic logic [31:0] mm(input logic [31:0] a);
        return 32'h5A00_0000 ^ (a * 32'd7);
    endfunction

    // Synchronous-read register file and data memory models.
    always @(posedge clk) begin
        reg_rd  <= rf(o_reg_addr);
        mem_rd  <= mm(o_mem_addr);
        reg2_rd <= rf(reg2_addr);
        mem2_rd <= mm(mem2_addr);
    end

    int          step_n = 0, start_n = 0, step2_n = 0, we_n = 0;
    logic [31:0] we_d [8];
    logic [31:0] we_a [8];
    always @(negedge clk) begin
        if (o_step)  step_n  <= step_n + 1;
        if (o_start) start_n <= start_n + 1;
        if (step2)   step2_n <= step2_n + 1;
        if (o_instr_we && we_n < 8) begin
            we_d[we_n] <= o_instr;
            we_a[we_n] <= o_instr_addr;
            we_n       <= we_n + 1;
        end
    end

    logic any1, any2;
    assign any1 = |{o_tx_data, o_tx_valid, o_instr, o_instr_addr, o_instr_we, o_loading,
                    o_start, o_step, o_reg_addr, o_mem_addr};
    assign any2 = |{tx2_data, tx2_valid, instr2, instr2_addr, instr2_we, loading2,
                    start2, step2, reg2_addr, mem2_addr};

    int errors = 0, checks = 0, hold_err = 0;
    logic [7:0] db [0:299];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input bit d2, input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        if (d2) rx2_valid = 1'b1; else rx_valid = 1'b1;
        @(negedge clk);
        rx_valid  = 1'b0;
        rx2_valid = 1'b0;
    endtask

    function automatic logic [31:0] dw(input int i);
        return {db[4*i+3], db[4*i+2], db[4*i+1], db[4*i]};
    endfunction

    task automatic collect(input bit d2, input int n, input bit toggle);
        int got = 0, cyc = 0;
        bit held = 0;
        logic v;
        logic [7:0] dt, hb = 8'h00;
        hold_err = 0;
        while (got < n && cyc < 20000) begin
            v  = d2 ? tx2_valid : o_tx_valid;
            dt = d2 ? tx2_data : o_tx_data;
            if (held && (!v || dt !== hb)) hold_err++;
            tx_ready = toggle ? ~tx_ready : 1'b1;
            if (v && tx_ready) begin
                db[got] = dt;
                got++;
                held = 0;
            end else begin
                held = v;
                hb   = dt;
            end
            @(negedge clk);
            cyc++;
        end
        tx_ready = 1'b1;
        chk("dump_len", 64'(got), 64'(n));
        chk("dump_end_idle", d2 ? tx2_valid : o_tx_valid, 1'b0);
    endtask

    task automatic check_dump(input string tag, input int nregs, input int nmem,
                              input logic [31:0] pc_exp, input logic [31:0] cyc_exp);
        int bad_r = 0, bad_m = 0;
        for (int k = 0; k < nregs; k++)
            if (dw(2 + k) !== rf(5'(k))) bad_r++;
        for (int m = 0; m < nmem; m++)
            if (dw(2 + nregs + m) !== mm(32'(4 * m))) bad_m++;
        chk({tag, "_pc"}, dw(0), pc_exp);
        chk({tag, "_cyc"}, dw(1), cyc_exp);
        chk({tag, "_regs_bad"}, 64'(bad_r), 64'd0);
        chk({tag, "_mem_bad"}, 64'(bad_m), 64'd0);
    endtask

    initial begin
        int k, s0, st0, w0;
        logic [7:0] prog [8];
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx2_valid = 1'b0;
        tx_ready = 1'b1; finish = 1'b0; pc = 32'h0040_0028;
        prog = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        repeat (2) @(negedge clk);
        chk("rst_outs", any1, 1'b0);
        chk("rst_outs2", any2, 1'b0);
        rst = 1'b0;

        // Program load of two words
        w0 = we_n;
        send_byte(0, 8'h4C);
        chk("loading_hi", o_loading, 1'b1);
        send_byte(0, 8'h02);
        for (int i = 0; i < 8; i++) send_byte(0, prog[i]);
        repeat (2) @(negedge clk);
        chk("we_count", 64'(we_n - w0), 64'd2);
        chk("we0_data", we_d[w0], 32'h1234_5678);
        chk("we0_addr", we_a[w0], 32'd0);
        chk("we1_data", we_d[w0+1], 32'hDEAD_BEEF);
        chk("we1_addr", we_a[w0+1], 32'd4);
        chk("loading_lo", o_loading, 1'b0);

        // Two single steps
        for (int s = 1; s <= 2; s++) begin
            s0 = step_n;
            send_byte(0, 8'h53);
            chk("step_now", o_step, 1'b1);
            collect(0, 264, 0);
            check_dump("step", 32, 32, pc, 32'(s));
            @(negedge clk);
            chk("step_pulses", 64'(step_n - s0), 64'd1);
        end

        // Continuous run, finish in the 10th o_start cycle
        pc = 32'h0040_0040;
        send_byte(0, 8'h43);
        k = 0;
        for (int c = 0; c < 50; c++) begin
            if (o_start) begin
                k++;
                if (k == 10) finish = 1'b1;
            end else if (k > 0) break;
            @(negedge clk);
        end
        finish = 1'b0;
        chk("run_cycles", 64'(k), 64'd10);
        collect(0, 264, 0);
        check_dump("run", 32, 32, pc, 32'd12);

        // Halted: C and S only dump
        s0 = step_n; st0 = start_n;
        send_byte(0, 8'h43);
        collect(0, 264, 0);
        send_byte(0, 8'h53);
        collect(0, 264, 0);
        check_dump("halted", 32, 32, pc, 32'd12);
        @(negedge clk);
        chk("halted_no_start", 64'(start_n - st0), 64'd0);
        chk("halted_no_step", 64'(step_n - s0), 64'd0);

        // Dump with TX backpressure
        send_byte(0, 8'h44);
        collect(0, 264, 1);
        chk("bp_hold", 64'(hold_err), 64'd0);
        check_dump("bp", 32, 32, pc, 32'd12);

        // Reset in the middle of a dump
        send_byte(0, 8'h44);
        for (int c = 0; c < 100 && !o_tx_valid; c++) @(negedge clk);
        chk("dump_started", o_tx_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_mid_dump", any1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        send_byte(0, 8'h44);
        collect(0, 264, 0);
        check_dump("post_rst", 32, 32, pc, 32'd0);

        // Reset in the middle of a load, then a fresh one-word load
        send_byte(0, 8'h4C);
        send_byte(0, 8'h03);
        send_byte(0, 8'hAA);
        send_byte(0, 8'hBB);
        rst = 1'b1;
        #1;
        chk("rst_mid_load", any1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        w0 = we_n;
        send_byte(0, 8'h4C);
        send_byte(0, 8'h01);
        send_byte(0, 8'h44);
        send_byte(0, 8'h33);
        send_byte(0, 8'h22);
        send_byte(0, 8'h11);
        repeat (2) @(negedge clk);
        chk("reload_count", 64'(we_n - w0), 64'd1);
        chk("reload_data", we_d[w0], 32'h1122_3344);
        chk("reload_addr", we_a[w0], 32'd0);

        // Halted cleared by reset: step works again
        send_byte(0, 8'h53);
        chk("step_after_rst", o_step, 1'b1);
        collect(0, 264, 0);
        chk("step_after_rst_cyc", dw(1), 32'd1);

        // Timeout instance: 5 run cycles, halted stays clear
        send_byte(1, 8'h43);
        k = 0;
        for (int c = 0; c < 50; c++) begin
            if (start2) k++;
            else if (k > 0) break;
            @(negedge clk);
        end
        chk("timeout_cycles", 64'(k), 64'd5);
        collect(1, 32, 0);
        check_dump("to", 4, 2, pc, 32'd5);
        s0 = step2_n;
        send_byte(1, 8'h53);
        chk("to_step_now", step2, 1'b1);
        collect(1, 32, 0);
        chk("to_step_cyc", dw(1), 32'd6);
        @(negedge clk);
        chk("to_step_pulses", 64'(step2_n - s0), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
